// File: rtl/clk_freq_meter_pkg.sv
// Shared definitions for the clock frequency meter: FSM encoding, ARM settle
// length and the helpers that size the result and gate counter.
package clk_freq_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_LATCH   = 2'd3
  } meter_state_e;

  // Cycles spent in ARM so the synchronizer holds settled data before counting.
  localparam int ARM_CYCLES = 3;

  // Width of the reported frequency: transition count scaled by the divider.
  function automatic int result_width(input int count_width, input int div_log2);
    return count_width + div_log2;
  endfunction

  // Width of a counter that must be able to hold values 0..gate_cycles.
  function automatic int gate_width(input int gate_cycles);
    return $clog2(gate_cycles + 1);
  endfunction

endpackage

// File: rtl/clk_freq_meter_sync_toggle_edge.sv
// sync_toggle_edge block: two-flop synchronizer for an asynchronous toggle,
// plus a third flop so any transition of the synchronized level produces a
// one-cycle pulse. Synchronous clear returns all three flops to 0. Also used
// for other asynchronous status bits.
module clk_freq_meter_sync_toggle_edge (
  input  logic clk,
  input  logic clear,
  input  logic async_in,
  output logic edge_pulse
);

  // sync_q[0] = s1, sync_q[1] = s2, sync_q[2] = s3
  logic [2:0] sync_q;

  // Shift the async input through the synchronizer and edge-detect flop.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so each flop samples the value its
    // neighbour held before the edge; blocking here would collapse the chain.
    if (clear) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], async_in};
    end
  end

  // Rising and falling transitions of the synchronized level both count.
  assign edge_pulse = sync_q[1] ^ sync_q[2];

endmodule

// File: rtl/clk_freq_meter.sv
// Reference-domain frequency meter. Counts transitions of a divided toggle
// from the measured clock domain over a fixed gate window and reports the
// measured-clock cycles per window, with range alarms, a no-clock flag and a
// valid/read handshake for the host.
module clk_freq_meter
  import clk_freq_meter_pkg::*;
#(
  parameter int DIV_LOG2    = 5,
  parameter int GATE_CYCLES = 48000,
  parameter int COUNT_WIDTH = 16,
  parameter int FREQ_MIN    = 0,
  parameter int FREQ_MAX    = 500000
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            MEAS_TOGGLE,
  input  logic                            ENABLE,
  input  logic                            RD_EN,
  output logic [COUNT_WIDTH+DIV_LOG2-1:0] FREQ,
  output logic                            VALID,
  output logic                            OVERRUN,
  output logic                            SAT,
  output logic                            NO_CLOCK,
  output logic                            ALARM
);

  localparam int RW = result_width(COUNT_WIDTH, DIV_LOG2);
  localparam int GW = gate_width(GATE_CYCLES);

  // Bounds are compared at result width, so out-of-range values truncate.
  localparam logic [RW-1:0] FREQ_MIN_T = RW'(FREQ_MIN);
  localparam logic [RW-1:0] FREQ_MAX_T = RW'(FREQ_MAX);
  localparam logic [GW-1:0] GATE_LAST  = GW'(GATE_CYCLES - 1);
  localparam logic [1:0]    ARM_LAST   = 2'(ARM_CYCLES - 1);

  meter_state_e           state;
  logic [1:0]             arm_cnt;
  logic [GW-1:0]          gate_cnt;
  logic [COUNT_WIDTH-1:0] trans_cnt;
  logic                   sat_seen;
  logic                   edge_det;

  logic [RW-1:0]          freq_new;
  logic                   no_clock_new;
  logic                   below_min;
  logic                   above_max;
  logic                   alarm_new;

  clk_freq_meter_sync_toggle_edge u_sync (
    .clk        (CLK),
    .clear      (RESET),
    .async_in   (MEAS_TOGGLE),
    .edge_pulse (edge_det)
  );

  // A zero lower bound can never trip, so skip the always-false compare.
  if (FREQ_MIN_T == '0) begin : g_no_min
    assign below_min = 1'b0;
  end else begin : g_min
    assign below_min = (freq_new < FREQ_MIN_T);
  end

  // An all-ones upper bound can never trip either.
  if (FREQ_MAX_T == '1) begin : g_no_max
    assign above_max = 1'b0;
  end else begin : g_max
    assign above_max = (freq_new > FREQ_MAX_T);
  end

  // Result candidate computed from the running count, used in the LATCH cycle.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path; a missed
    // assignment would infer a latch.
    freq_new     = RW'(trans_cnt) << DIV_LOG2;
    no_clock_new = (trans_cnt == '0);
    alarm_new    = no_clock_new | below_min | above_max;
  end

  // Measurement FSM, counters and registered result/handshake outputs.
  always_ff @(posedge CLK) begin
    // NOTE: synchronous reset gives every register here a defined value; a
    // mid-window reset therefore discards the partial count as well.
    if (RESET) begin
      state     <= ST_IDLE;
      arm_cnt   <= '0;
      gate_cnt  <= '0;
      trans_cnt <= '0;
      sat_seen  <= 1'b0;
      FREQ      <= '0;
      VALID     <= 1'b0;
      OVERRUN   <= 1'b0;
      SAT       <= 1'b0;
      NO_CLOCK  <= 1'b0;
      ALARM     <= 1'b0;
    end else begin
      // Host read; a LATCH in the same cycle overrides VALID/OVERRUN below.
      if (RD_EN && VALID) begin
        VALID   <= 1'b0;
        OVERRUN <= 1'b0;
      end

      unique case (state)
        ST_IDLE: begin
          arm_cnt   <= '0;
          gate_cnt  <= '0;
          trans_cnt <= '0;
          sat_seen  <= 1'b0;
          if (ENABLE) begin
            state <= ST_ARM;
          end
        end

        ST_ARM: begin
          if (!ENABLE) begin
            arm_cnt <= '0;
            state   <= ST_IDLE;
          end else if (arm_cnt == ARM_LAST) begin
            arm_cnt   <= '0;
            gate_cnt  <= '0;
            trans_cnt <= '0;
            sat_seen  <= 1'b0;
            state     <= ST_MEASURE;
          end else begin
            arm_cnt <= arm_cnt + 2'd1;
          end
        end

        ST_MEASURE: begin
          if (!ENABLE) begin
            gate_cnt  <= '0;
            trans_cnt <= '0;
            sat_seen  <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            if (edge_det) begin
              if (&trans_cnt) begin
                sat_seen <= 1'b1;
              end else begin
                trans_cnt <= trans_cnt + 1'b1;
              end
            end
            if (gate_cnt == GATE_LAST) begin
              gate_cnt <= '0;
              state    <= ST_LATCH;
            end else begin
              gate_cnt <= gate_cnt + 1'b1;
            end
          end
        end

        ST_LATCH: begin
          FREQ     <= freq_new;
          SAT      <= sat_seen;
          NO_CLOCK <= no_clock_new;
          ALARM    <= alarm_new;
          VALID    <= 1'b1;
          // Overwriting an unread result flags an overrun unless read now.
          OVERRUN  <= VALID && !RD_EN;
          gate_cnt <= '0;
          sat_seen <= 1'b0;
          if (ENABLE) begin
            // The edge seen in this cycle opens the next window.
            trans_cnt <= COUNT_WIDTH'(edge_det);
            state     <= ST_MEASURE;
          end else begin
            trans_cnt <= '0;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_freq_meter.sv
// Directed bench for clk_freq_meter with GATE_CYCLES=100, DIV_LOG2=5,
// FREQ_MIN=500, FREQ_MAX=1000. A second instance with COUNT_WIDTH=5 shares
// the stimulus to exercise saturation.
module tb_clk_freq_meter;

  logic        clk = 1'b0;
  logic        reset;
  logic        meas_toggle;
  logic        enable;
  logic        rd_en;

  logic [12:0] freq;
  logic        valid, overrun, sat, no_clock, alarm;
  logic [9:0]  freq_s;
  logic        valid_s, overrun_s, sat_s, no_clock_s, alarm_s;

  int checks   = 0;
  int failures = 0;
  int tog_period = 0;
  int ph = 0;

  always #5 clk = ~clk;

  clk_freq_meter #(
    .DIV_LOG2(5), .GATE_CYCLES(100), .COUNT_WIDTH(8),
    .FREQ_MIN(500), .FREQ_MAX(1000)
  ) dut (
    .CLK(clk), .RESET(reset), .MEAS_TOGGLE(meas_toggle), .ENABLE(enable),
    .RD_EN(rd_en), .FREQ(freq), .VALID(valid), .OVERRUN(overrun),
    .SAT(sat), .NO_CLOCK(no_clock), .ALARM(alarm)
  );

  clk_freq_meter #(
    .DIV_LOG2(5), .GATE_CYCLES(100), .COUNT_WIDTH(5),
    .FREQ_MIN(500), .FREQ_MAX(1000)
  ) dut_s (
    .CLK(clk), .RESET(reset), .MEAS_TOGGLE(meas_toggle), .ENABLE(enable),
    .RD_EN(rd_en), .FREQ(freq_s), .VALID(valid_s), .OVERRUN(overrun_s),
    .SAT(sat_s), .NO_CLOCK(no_clock_s), .ALARM(alarm_s)
  );

  // Toggle generator: flips meas_toggle every tog_period CLK cycles (0 = hold).
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (tog_period != 0) begin
        ph = ph + 1;
        if (ph >= tog_period) begin
          ph = 0;
          meas_toggle = ~meas_toggle;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_in(input string tag, input int obs, input int a, input int b);
    checks++;
    assert (obs === a || obs === b) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d or %0d", tag, obs, a, b);
    end
  endtask

  // Ticks until VALID is seen; cyc = ticks taken, expiry counts as a failure.
  task automatic wait_valid(input string tag, input int budget, output int cyc);
    cyc = 0;
    while (valid !== 1'b1 && cyc < budget) begin
      tick();
      cyc++;
    end
    if (valid !== 1'b1) begin
      checks++;
      failures++;
      $error("FAIL %s: VALID not seen within %0d cycles", tag, budget);
    end
  endtask

  initial begin
    int cyc;
    int f2, f3, sum;

    reset = 1'b1; enable = 1'b0; rd_en = 1'b0; meas_toggle = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_freq",     int'(freq),     0);
    check("rst_valid",    int'(valid),    0);
    check("rst_overrun",  int'(overrun),  0);
    check("rst_sat",      int'(sat),      0);
    check("rst_no_clock", int'(no_clock), 0);
    check("rst_alarm",    int'(alarm),    0);
    reset = 1'b0;
    tick();
    check("idle_valid", int'(valid), 0);

    // 1: toggle every 4 CLK -> 25 edges, 800. ENABLE is sampled on the first
    // tick, VALID appears 104 edges later, i.e. on tick 105.
    tog_period = 4;
    repeat (10) tick();
    enable = 1'b1;
    wait_valid("t1_wait", 300, cyc);
    check("t1_latency",   cyc,             105);
    check("t1_freq",      int'(freq),      800);
    check("t1_alarm",     int'(alarm),     0);
    check("t1_no_clock",  int'(no_clock),  0);
    check("t1_sat",       int'(sat),       0);
    check("t1_overrun",   int'(overrun),   0);
    check("t1_freq_s",    int'(freq_s),    800);
    check("t1_sat_s",     int'(sat_s),     0);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("t1_rd_valid",  int'(valid),     0);
    enable = 1'b0;
    repeat (2) tick();

    // 2: constant input -> no clock
    tog_period = 0;
    repeat (4) tick();
    enable = 1'b1;
    wait_valid("t2_wait", 300, cyc);
    check("t2_latency",   cyc,             105);
    check("t2_freq",      int'(freq),      0);
    check("t2_no_clock",  int'(no_clock),  1);
    check("t2_alarm",     int'(alarm),     1);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("t2_rd_valid",  int'(valid),     0);
    enable = 1'b0;
    repeat (2) tick();

    // 3 + 4: toggle every 2 CLK, three windows, no reads
    tog_period = 2;
    repeat (10) tick();
    enable = 1'b1;
    wait_valid("t3_wait", 300, cyc);
    check("t3_freq1",     int'(freq),      1600);
    check("t3_alarm1",    int'(alarm),     1);
    check("t3_overrun1",  int'(overrun),   0);
    check("t4_freq_s",    int'(freq_s),    992);
    check("t4_sat_s",     int'(sat_s),     1);
    check("t4_alarm_s",   int'(alarm_s),   0);
    repeat (100) tick();
    check("t3_pre_latch_overrun", int'(overrun), 0);
    tick();
    f2 = int'(freq);
    check("t3_overrun2",  int'(overrun),   1);
    check("t3_valid2",    int'(valid),     1);
    check("t3_alarm2",    int'(alarm),     1);
    check_in("t3_freq2",  f2, 1600, 1632);
    check("t4_freq_s2",   int'(freq_s),    992);
    repeat (101) tick();
    f3 = int'(freq);
    check("t3_overrun3",  int'(overrun),   1);
    check_in("t3_freq3",  f3, 1600, 1632);
    check("t3_sum23",     f2 + f3,         3232);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("t3_rd_valid",   int'(valid),    0);
    check("t3_rd_overrun", int'(overrun),  0);
    check("t3_rd_valid_s", int'(valid_s),  0);
    enable = 1'b0;
    repeat (2) tick();

    // 5: abort mid-window, then reset mid-window
    tog_period = 4;
    repeat (10) tick();
    enable = 1'b1;
    wait_valid("t5_wait", 300, cyc);
    check("t5_freq",      int'(freq),      800);
    repeat (50) tick();
    enable = 1'b0;
    repeat (60) tick();
    check("t5_abort_valid",   int'(valid),   1);
    check("t5_abort_overrun", int'(overrun), 0);
    check("t5_abort_freq",    int'(freq),    800);
    enable = 1'b1;
    repeat (60) tick();
    check("t5_mid_valid", int'(valid),     1);
    check("t5_mid_freq",  int'(freq),      800);
    reset = 1'b1; enable = 1'b0;
    tick();
    check("t5_rst_valid",    int'(valid),    0);
    check("t5_rst_freq",     int'(freq),     0);
    check("t5_rst_overrun",  int'(overrun),  0);
    check("t5_rst_sat",      int'(sat),      0);
    check("t5_rst_no_clock", int'(no_clock), 0);
    check("t5_rst_alarm",    int'(alarm),    0);
    check("t5_rst_valid_s",  int'(valid_s),  0);
    check("t5_rst_freq_s",   int'(freq_s),   0);
    reset = 1'b0;
    repeat (2) tick();

    // 6: back-to-back windows, read in each LATCH cycle; four contiguous
    // 101-cycle windows at one edge per 4 cycles hold exactly 101 edges.
    enable = 1'b1;
    wait_valid("t6_wait", 300, cyc);
    check("t6_freq1",     int'(freq),      800);
    sum = 0;
    for (int w = 0; w < 4; w++) begin
      repeat (100) tick();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check_in("t6_freq",  int'(freq), 800, 832);
      check("t6_valid",    int'(valid),   1);
      check("t6_overrun",  int'(overrun), 0);
      sum = sum + int'(freq);
    end
    check("t6_sum", sum, 3232);
    enable = 1'b0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
